pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 87 ++++++++
 tb/tb_pc_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with branch/jump/jr redirect, one-entry stall-time redirect buffer, fault flag and fetch counter.
// One-cycle latency from next-PC select to PC_Out; stall holds the PC and buffers the newest redirect.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic [31:0] br_base,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] PC_Out,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [1:0]  NPC_SEQ    = 2'b00;
  localparam logic [1:0]  NPC_BRANCH = 2'b01;
  localparam logic [1:0]  NPC_JUMP   = 2'b10;
  localparam logic [1:0]  NPC_JR     = 2'b11;
  localparam logic [31:0] PC_RESET   = 32'h0000_3000;

  logic [31:0] base_plus4;
  logic [31:0] branch_offset;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] live_tgt;
  logic [31:0] next_pc;
  logic [31:0] pending_tgt;
  logic        live_redirect;
  logic        next_illegal;

  assign base_plus4    = br_base + 32'd4;
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_tgt    = base_plus4 + branch_offset;
  assign jump_tgt      = {base_plus4[31:28], instr_index, 2'b00};
  assign live_redirect = (npc_op != NPC_SEQ);
  assign pc_plus4      = PC_Out + 32'd4;

  always_comb begin
    live_tgt = pc_plus4;
    case (npc_op)
      NPC_BRANCH: live_tgt = branch_tgt;
      NPC_JUMP:   live_tgt = jump_tgt;
      NPC_JR:     live_tgt = jr_target;
      default:    live_tgt = pc_plus4;
    endcase
  end

  // A live redirect outranks a buffered one; the buffer only replaces the sequential step.
  always_comb begin
    next_pc = pc_plus4;
    if (live_redirect) begin
      next_pc = live_tgt;
    end else if (redirect_pending) begin
      next_pc = pending_tgt;
    end
  end

  // Legal fetch window is word-aligned 0x3000..0x3FFC.
  assign next_illegal = (next_pc[1:0] != 2'b00) || (next_pc[31:12] != 20'h00003);

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_Out           <= PC_RESET;
      pending_tgt      <= 32'd0;
      redirect_pending <= 1'b0;
      fetch_fault      <= 1'b0;
      fetch_count      <= 32'd0;
    end else if (stall) begin
      if (live_redirect) begin
        pending_tgt      <= live_tgt;
        redirect_pending <= 1'b1;
      end
    end else begin
      PC_Out           <= next_pc;
      redirect_pending <= 1'b0;
      fetch_count      <= fetch_count + 32'd1;
      if (next_illegal) begin
        fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus random stimulus against a behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic [31:0] br_base;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] PC_Out;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .br_base(br_base), .imm16(imm16), .instr_index(instr_index), .jr_target(jr_target),
    .PC_Out(PC_Out), .pc_plus4(pc_plus4), .redirect_pending(redirect_pending),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        m_fault;
  logic [31:0] m_cnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] target_of(input logic [1:0] op, input logic [31:0] base,
                                            input logic [15:0] imm, input logic [25:0] idx,
                                            input logic [31:0] jr);
    int signed words;
    words = $signed(imm);
    case (op)
      2'b01:   return base + 32'd4 + 32'(words * 4);
      2'b10:   return ((base + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
      default: return jr;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a >= 32'h3000) && (a <= 32'h3FFC) && (a % 4 == 0);
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, queue the post-edge expectation.
  task automatic step(input logic r, input logic s, input logic [1:0] op, input logic [31:0] base,
                      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    logic [31:0] tgt;
    logic [31:0] nxt;
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; npc_op = op; br_base = base; imm16 = imm; instr_index = idx; jr_target = jr;
    tgt = target_of(op, base, imm, idx, jr);
    if (r) begin
      m_pc = 32'h3000; m_pend = 1'b0; m_ptgt = 32'h0; m_fault = 1'b0; m_cnt = 32'h0;
    end else if (s) begin
      if (op != 2'b00) begin
        m_pend = 1'b1; m_ptgt = tgt;
      end
    end else begin
      if (op != 2'b00)  nxt = tgt;
      else if (m_pend)  nxt = m_ptgt;
      else              nxt = m_pc + 32'd4;
      m_pend = 1'b0;
      m_pc   = nxt;
      if (!legal(nxt)) m_fault = 1'b1;
      m_cnt  = m_cnt + 32'd1;
    end
    e.pc = m_pc; e.pend = m_pend; e.fault = m_fault; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic seq(input logic s);
    step(1'b0, s, 2'b00, 32'h3000, 16'h0, 26'h0, 32'h3000);
  endtask

  task automatic jr_to(input logic s, input logic [31:0] t);
    step(1'b0, s, 2'b11, 32'h3000, 16'h0, 26'h0, t);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge the DUT presents a new state; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("sb_pc", PC_Out, e.pc);
        cmp("sb_plus4", pc_plus4, e.pc + 32'd4);
        cmp("sb_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
        cmp("sb_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
        cmp("sb_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] jr;
    logic [31:0] base;
    reset = 1'b1; stall = 1'b0; npc_op = 2'b00; br_base = 32'h0; imm16 = 16'h0;
    instr_index = 26'h0; jr_target = 32'h0;
    m_pc = 32'h0; m_pend = 1'b0; m_ptgt = 32'h0; m_fault = 1'b0; m_cnt = 32'h0;

    step(1'b1, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
    settle();
    cmp("rst_pc", PC_Out, 32'h3000);
    cmp("rst_plus4", pc_plus4, 32'h3004);
    cmp("rst_count", fetch_count, 32'd0);

    seq(1'b0); settle(); cmp("seq1", PC_Out, 32'h3004);
    seq(1'b0); settle(); cmp("seq2", PC_Out, 32'h3008);
    seq(1'b0); settle(); cmp("seq3", PC_Out, 32'h300C);
    cmp("seq_count", fetch_count, 32'd3);

    step(1'b0, 1'b0, 2'b01, 32'h3010, 16'hFFFC, 26'h0, 32'h0); settle();
    cmp("branch_back", PC_Out, 32'h3004);
    step(1'b0, 1'b0, 2'b10, 32'h3010, 16'h0, 26'h0000C40, 32'h0); settle();
    cmp("jump", PC_Out, 32'h3100);

    jr_to(1'b0, 32'h3020); settle();
    jr_to(1'b1, 32'h3200); settle();
    cmp("stall_hold", PC_Out, 32'h3020);
    cmp("stall_pending", {31'd0, redirect_pending}, 32'd1);
    cmp("stall_count", fetch_count, 32'd6);
    seq(1'b0); settle();
    cmp("pend_load", PC_Out, 32'h3200);
    cmp("pend_clear", {31'd0, redirect_pending}, 32'd0);

    jr_to(1'b1, 32'h3200); jr_to(1'b1, 32'h3300); seq(1'b0); settle();
    cmp("newest_wins", PC_Out, 32'h3300);
    jr_to(1'b1, 32'h3200); jr_to(1'b1, 32'h3300); jr_to(1'b0, 32'h3400); settle();
    cmp("live_wins", PC_Out, 32'h3400);
    cmp("live_clear", {31'd0, redirect_pending}, 32'd0);

    jr_to(1'b1, 32'h3202); settle();
    cmp("no_fault_on_capture", {31'd0, fetch_fault}, 32'd0);
    seq(1'b0); settle();
    cmp("fault_set", {31'd0, fetch_fault}, 32'd1);
    seq(1'b0); settle();
    cmp("fault_sticky", {31'd0, fetch_fault}, 32'd1);

    step(1'b1, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
    jr_to(1'b0, 32'h3FFC); seq(1'b0); settle();
    cmp("wrap_pc", PC_Out, 32'h4000);
    cmp("wrap_fault", {31'd0, fetch_fault}, 32'd1);

    step(1'b1, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
    jr_to(1'b1, 32'h3100);
    step(1'b1, 1'b1, 2'b11, 32'h0, 16'h0, 26'h0, 32'h3500); settle();
    cmp("rst_stall_pc", PC_Out, 32'h3000);
    cmp("rst_stall_pend", {31'd0, redirect_pending}, 32'd0);
    cmp("rst_stall_count", fetch_count, 32'd0);
    seq(1'b0); settle();
    cmp("rst_discard", PC_Out, 32'h3004);

    for (int i = 0; i < 2000; i++) begin
      op   = 2'($urandom_range(0, 3));
      base = 32'h3000 + 32'($urandom_range(0, 1023)) * 32'd4;
      jr   = ($urandom_range(0, 15) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 1023)) * 32'd4;
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30), op, base,
           16'($urandom_range(0, 63)) - 16'd32,
           ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'h0000C00 + 26'($urandom_range(0, 1023)),
           jr);
    end

    repeat (3) @(posedge clk);
    #2;
    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
